apb_req_arbiter: RTL
====================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, wait-cycle limit per transfer in ACCESS_WAIT (1..255).
REQ-002 pclk  input  1  clock; all state updates on rising edge.
REQ-003 preset  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_i / req1_i  input  1  requester n has a transfer pending; held until its done pulse.
REQ-005 rw0_i / rw1_i  input  1  requester n direction, 1=read, 0=write.
REQ-006 addr0_i / addr1_i  input  33  requester n address; bit 32 set = unmapped.
REQ-007 wdata0_i / wdata1_i  input  32  requester n write data.
REQ-008 transfer  output  1  transfer request to APB master.
REQ-009 Read_write  output  1  direction to master, 1=read.
REQ-010 read_addr / write_addr  output  33  master address; the one not selected by Read_write is driven 0.
REQ-011 write_data  output  32  master write data; 0 on reads.
REQ-012 psel, penable, pready  input  1 each  APB bus observation; completion = psel&penable&pready.
REQ-013 PSlavErr  input  1  master error flag.
REQ-014 readOut  input  32  master read capture.
REQ-015 done0_o / done1_o  output  1  one-cycle completion pulse to requester n.
REQ-016 err0_o / err1_o  output  1  valid with done pulse; 1 = error, timeout or unmapped.
REQ-017 rdata_o  output  32  read data, valid with the done pulse of a read.
REQ-018 grant_o  output  2  one-hot current owner; 00 when idle.

Function
REQ-019 States: IDLE, ISSUE, ACCESS_WAIT, RESP; 2-bit encoding; default case goes to IDLE.
REQ-020 IDLE: no request -> stay; a request -> latch owner, rw, addr, wdata; go to ISSUE next cycle.
REQ-021 Arbitration: round-robin. Pointer selects the preferred requester (reset value 0). A sole requester wins.
REQ-022 Pointer moves to the non-winner on each grant.
REQ-023 Latched addr bit 32 = 1: skip the bus, go IDLE -> RESP, err=1, rdata_o=0, transfer never asserted.
REQ-024 ISSUE: transfer=1 with latched command; next state ACCESS_WAIT.
REQ-025 ACCESS_WAIT: transfer held at 1; 8-bit wait counter increments each cycle.
REQ-026 Completion seen -> capture readOut (reads) and PSlavErr; go to RESP.
REQ-027 PSlavErr=1 in ISSUE or ACCESS_WAIT -> go to RESP with err=1 and do not wait for completion.
REQ-028 Counter reaches TIMEOUT without completion -> go to RESP with err=1 and rdata_o=0.
REQ-029 transfer deasserts on the cycle RESP is entered.
REQ-030 RESP: exactly one cycle; done of the owner =1, err/rdata_o per capture; grant_o still the owner; then IDLE.
REQ-031 Minimum latency, request to done, with zero-wait slave: IDLE(1) + ISSUE(1) + ACCESS_WAIT until completion + RESP.
REQ-032 A new grant occurs no earlier than the cycle after RESP; no back-to-back grant without IDLE.
REQ-033 Requester inputs are ignored while not IDLE; latched command is stable from ISSUE through RESP.
REQ-034 Owner's req drops mid-transfer -> transfer completes normally, done still pulses.
REQ-035 Both requests arriving in the same IDLE cycle -> pointer owner wins; the other is served next.
REQ-036 Counter clears in IDLE.

Reset
REQ-037 preset=0 asynchronously forces these values:
- state IDLE, pointer 0, counter 0
- transfer=0, Read_write=1
- all addresses, write_data and rdata_o = 0
- done/err = 0, grant_o = 00
REQ-038 Reset mid-transfer aborts without any done pulse; first grant after release follows REQ-020.

Verification
REQ-039 req0 write, addr 0x0_0000_0010, wdata 0xA5A5A5A5, pready at first access -> write_addr=0x10, write_data=0xA5A5A5A5, done0 one cycle, err0=0.
REQ-040 req0 and req1 reads together from reset -> requester 0 is served first, then requester 1; grant_o 01 then 10; rdata_o = readOut at each done.
REQ-041 req1 addr 0x1_0000_0000 -> no transfer assertion; done1=1, err1=1 two cycles after request.
REQ-042 TIMEOUT=4, pready held 0 -> done=1, err=1 after 4 ACCESS_WAIT cycles; transfer low in RESP.
REQ-043 PSlavErr pulse during ACCESS_WAIT -> immediate RESP, err=1, rdata_o=0.
REQ-044 preset low during ACCESS_WAIT -> all outputs at reset values at once, no done; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin front end for an APB master
// Latches one command per grant, tracks completion/error/timeout and returns a done pulse.
module apb_req_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        rw0_i,
  input  logic        rw1_i,
  input  logic [32:0] addr0_i,
  input  logic [32:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        transfer,
  output logic        Read_write,
  output logic [32:0] read_addr,
  output logic [32:0] write_addr,
  output logic [31:0] write_data,
  input  logic        psel,
  input  logic        penable,
  input  logic        pready,
  input  logic        PSlavErr,
  input  logic [31:0] readOut,
  output logic        done0_o,
  output logic        done1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    ACCESS_WAIT = 2'd2,
    RESP        = 2'd3
  } state_t;

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        rw_q, rw_d;
  logic [32:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        transfer_q, transfer_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        bus_done;
  logic        win;
  logic [1:0]  owner_oh;
  logic [32:0] win_addr;

  assign bus_done = psel & penable & pready;
  // Contention goes to the pointer; otherwise whoever is asking.
  assign win      = (req0_i & req1_i) ? ptr_q : req1_i;
  assign win_addr = win ? addr1_i : addr0_i;
  assign owner_oh = owner_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    transfer_d = transfer_q;
    grant_d    = grant_q;
    done_d     = 2'b00;
    err_d      = 2'b00;
    rdata_d    = 32'd0;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (req0_i | req1_i) begin
          owner_d = win;
          ptr_d   = ~win;
          rw_d    = win ? rw1_i : rw0_i;
          addr_d  = win_addr;
          wdata_d = win ? wdata1_i : wdata0_i;
          grant_d = win ? 2'b10 : 2'b01;
          if (win_addr[32]) begin
            state_d = RESP;
            done_d  = win ? 2'b10 : 2'b01;
            err_d   = win ? 2'b10 : 2'b01;
          end else begin
            state_d    = ISSUE;
            transfer_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_d = 8'd0;
        if (PSlavErr) begin
          state_d    = RESP;
          transfer_d = 1'b0;
          done_d     = owner_oh;
          err_d      = owner_oh;
        end else begin
          state_d = ACCESS_WAIT;
        end
      end
      ACCESS_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (PSlavErr) begin
          state_d    = RESP;
          transfer_d = 1'b0;
          done_d     = owner_oh;
          err_d      = owner_oh;
        end else if (bus_done) begin
          state_d    = RESP;
          transfer_d = 1'b0;
          done_d     = owner_oh;
          rdata_d    = rw_q ? readOut : 32'd0;
        end else if (({1'b0, cnt_q} + 9'd1) >= TIMEOUT_LIM) begin
          state_d    = RESP;
          transfer_d = 1'b0;
          done_d     = owner_oh;
          err_d      = owner_oh;
        end
      end
      RESP: begin
        state_d    = IDLE;
        transfer_d = 1'b0;
        grant_d    = 2'b00;
      end
      default: begin
        state_d    = IDLE;
        transfer_d = 1'b0;
        grant_d    = 2'b00;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= 8'd0;
      owner_q    <= 1'b0;
      rw_q       <= 1'b1;
      addr_q     <= 33'd0;
      wdata_q    <= 32'd0;
      transfer_q <= 1'b0;
      grant_q    <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      transfer_q <= transfer_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign transfer   = transfer_q;
  assign Read_write = rw_q;
  assign read_addr  = rw_q ? addr_q : 33'd0;
  assign write_addr = rw_q ? 33'd0 : addr_q;
  assign write_data = rw_q ? 32'd0 : wdata_q;
  assign grant_o    = grant_q;
  assign done0_o    = done_q[0];
  assign done1_o    = done_q[1];
  assign err0_o     = err_q[0];
  assign err1_o     = err_q[1];
  assign rdata_o    = rdata_q;

endmodule
